uart_rx_ctrl: RTL

- UART receiver feeding the io_ram_datapath I/O window.
- Samples the asynchronous `rx` pin and deserialises 8N1 frames.
- Holds one received byte plus status flags, which the datapath reads through a load from the I/O region.
- A read strobe from the datapath consumes the byte, giving a one-deep buffer with overrun detection.

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_rx_ctrl_sync2.sv | 24 ++
 rtl/uart_rx_ctrl.sv | 110 +++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding, frame constants and datapath status word layout
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam int   DATA_BITS = 8;
    localparam logic UART_IDLE = 1'b1;

    localparam int ST_DATA_LSB  = 0;
    localparam int ST_VALID     = 8;
    localparam int ST_OVERRUN   = 9;
    localparam int ST_FRAME_ERR = 10;
    localparam int ST_BUSY      = 11;
    localparam int ST_W         = 12;

    function automatic logic [ST_W-1:0] pack_status(
        input logic [DATA_BITS-1:0] data,
        input logic                 valid,
        input logic                 overrun,
        input logic                 frame_err,
        input logic                 busy
    );
        return {busy, frame_err, overrun, valid, data};
    endfunction

endpackage

// File: rtl/uart_rx_ctrl_sync2.sv
// sync2: two-flop synchroniser with a selectable reset level
module sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // shift the asynchronous input through two flops to settle metastability
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: 8N1 UART receiver with a one-deep byte buffer and sticky error flags
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       rd,
    input  logic       clr_err,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       overrun,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [2:0]             bit_idx;
    logic [DATA_BITS-1:0]   shift;
    logic                   rx_s;

    sync2 #(.RST_VAL(UART_IDLE)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    // frame FSM; later assignments in a cycle override the rd/clr_err defaults so a commit wins
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            if (rd)
                rx_valid <= 1'b0;
            if (clr_err) begin
                overrun   <= 1'b0;
                frame_err <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == HALF_END) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == BIT_END) begin
                        cnt            <= '0;
                        shift[bit_idx] <= rx_s;
                        if (bit_idx == LAST_BIT)
                            state <= STOP;
                        else
                            bit_idx <= bit_idx + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == BIT_END) begin
                        cnt      <= '0;
                        rx_data  <= shift;
                        rx_valid <= 1'b1;
                        if (rx_valid && !rd)
                            overrun <= 1'b1;
                        if (!rx_s)
                            frame_err <= 1'b1;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
